// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-and-issue stage in front of the 16-bit ALU.
// Accepts MSP430-style register-mode Format I words and RRC, reads the
// register file, and issues registered operands. A pending scoreboard
// stalls on RAW/WAW hazards until the matching writeback returns.
// Optional feature macro: ALU_ISSUE_BYTE_EN. When it is defined, B/W=1 is
// legal, operands are zero-extended from their low byte, and alu_byte_o exists.

module alu_issue_stage #(
  parameter int NREG = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ins_valid_i,
  output logic        ins_ready_o,
  input  logic [15:0] ins_word_i,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic [4:0]  alu_sel_o,
  output logic [3:0]  alu_dst_o,
  output logic        alu_wb_o,
  output logic        alu_valid_o,
  output logic        illegal_o,
`ifdef ALU_ISSUE_BYTE_EN
  output logic        alu_byte_o,
`endif
  input  logic        wb_valid_i,
  input  logic        wb_en_i,
  input  logic [3:0]  wb_dst_i,
  input  logic [15:0] wb_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    ISSUE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [15:0]     word_q;
  logic [15:0]     regFile_q [NREG];
  logic [NREG-1:0] pending_q, pending_d;

  logic [15:0] aluA_q, aluB_q;
  logic [4:0]  aluSel_q;
  logic [3:0]  aluDst_q;
  logic        aluWb_q;
  logic        issueIllegal_q;
  logic        aluValid_q;
  logic        illegalPulse_q;
`ifdef ALU_ISSUE_BYTE_EN
  logic        aluByte_q;
`endif

  // Instruction word fields
  logic [3:0]  opField;
  logic [3:0]  srcIdx;
  logic [3:0]  dstIdx;
  logic        adBit;
  logic        bwBit;
  logic [1:0]  asBits;
  logic        isFormatI;
  logic        isRrc;

  assign opField   = word_q[15:12];
  assign srcIdx    = word_q[11:8];
  assign dstIdx    = word_q[3:0];
  assign adBit     = word_q[7];
  assign bwBit     = word_q[6];
  assign asBits    = word_q[5:4];
  assign isFormatI = (opField[3:2] != 2'b00);
  assign isRrc     = (word_q[15:10] == 6'b000100) && (word_q[9:7] == 3'b000);

  // Register reads use the pre-edge contents; a same-cycle writeback is not bypassed
  logic [15:0] rawSrc, rawDst, srcVal, dstVal;
  logic        bwIllegal;

  assign rawSrc = regFile_q[srcIdx];
  assign rawDst = regFile_q[dstIdx];

`ifdef ALU_ISSUE_BYTE_EN
  assign srcVal    = bwBit ? {8'h00, rawSrc[7:0]} : rawSrc;
  assign dstVal    = bwBit ? {8'h00, rawDst[7:0]} : rawDst;
  assign bwIllegal = 1'b0;
`else
  assign srcVal    = rawSrc;
  assign dstVal    = rawDst;
  assign bwIllegal = bwBit;
`endif

  // Illegal: indexed/indirect modes, unknown low opcodes, or an unsupported byte op.
  // For Format II bit 7 belongs to the opcode, so Ad is only checked on Format I.
  logic decIllegal;
  assign decIllegal = (asBits != 2'b00)
                    | (isFormatI & adBit)
                    | (~isFormatI & ~isRrc)
                    | bwIllegal;

  // Format I reads src and dst; RRC reads and writes its single register
  logic hazard;
  assign hazard = pending_q[dstIdx] | (isFormatI & pending_q[srcIdx]);

  logic doIssue;
  assign doIssue = (state_q == CHECK) && !decIllegal && !hazard;

  // Decode the latched word into ALU select, operand routing and writeback flag
  logic [4:0]  decSel;
  logic [15:0] decA, decB;
  logic        decWb;

  always_comb begin
    decSel = 5'b00000;
    decA   = 16'h0000;
    decB   = 16'h0000;
    decWb  = 1'b0;
    case (opField)
      4'h4: begin decSel = 5'b00000; decB = srcVal; decWb = 1'b1; end
      4'h5: begin decSel = 5'b00001; decA = dstVal; decB = srcVal; decWb = 1'b1; end
      4'h6: begin decSel = 5'b00010; decA = dstVal; decB = srcVal; decWb = 1'b1; end
      4'h7: begin decSel = 5'b00100; decA = dstVal; decB = srcVal; decWb = 1'b1; end
      4'h8: begin decSel = 5'b00011; decA = dstVal; decB = srcVal; decWb = 1'b1; end
      4'h9: begin decSel = 5'b00101; decA = dstVal; decB = srcVal; decWb = 1'b0; end
      4'hA: begin decSel = 5'b00110; decA = dstVal; decB = srcVal; decWb = 1'b1; end
      4'hB: begin decSel = 5'b00111; decA = srcVal; decB = dstVal; decWb = 1'b0; end
      4'hC: begin decSel = 5'b01000; decA = srcVal; decB = dstVal; decWb = 1'b1; end
      4'hD: begin decSel = 5'b01001; decA = srcVal; decB = dstVal; decWb = 1'b1; end
      4'hE: begin decSel = 5'b01010; decA = dstVal; decB = srcVal; decWb = 1'b1; end
      4'hF: begin decSel = 5'b01011; decA = dstVal; decB = srcVal; decWb = 1'b1; end
      default: begin decSel = 5'b10000; decB = dstVal; decWb = 1'b1; end
    endcase
  end

  // Next-state logic for the IDLE -> CHECK -> ISSUE sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ins_valid_i) state_d = CHECK;
      CHECK:   if (decIllegal || !hazard) state_d = ISSUE;
      ISSUE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Ready is held low while reset is asserted even though the state is IDLE
  assign ins_ready_o = rst_n && (state_q == IDLE);

  // Latch the instruction word on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   word_q <= 16'h0000;
    else if (state_q == IDLE && ins_valid_i)      word_q <= ins_word_i;
  end

  // Scoreboard update: writeback clears first, then an issue sets, so set wins
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_i)         pending_d[wb_dst_i] = 1'b0;
    if (doIssue && decWb)   pending_d[dstIdx]   = 1'b1;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Register file written only by returning writebacks with wb_en set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regFile_q[i] <= 16'h0000;
    end else if (wb_valid_i && wb_en_i) begin
      regFile_q[wb_dst_i] <= wb_data_i;
    end
  end

  // Operand outputs load on issue and hold until the next issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluA_q   <= 16'h0000;
      aluB_q   <= 16'h0000;
      aluSel_q <= 5'b00000;
      aluDst_q <= 4'h0;
      aluWb_q  <= 1'b0;
    end else if (doIssue) begin
      aluA_q   <= decA;
      aluB_q   <= decB;
      aluSel_q <= decSel;
      aluDst_q <= dstIdx;
      aluWb_q  <= decWb;
    end
  end

`ifdef ALU_ISSUE_BYTE_EN
  // Byte flag travels with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       aluByte_q <= 1'b0;
    else if (doIssue) aluByte_q <= bwBit;
  end

  assign alu_byte_o = aluByte_q;
`endif

  // Remember whether the word leaving CHECK was illegal so ISSUE picks the right strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  issueIllegal_q <= 1'b0;
    else if (state_q == CHECK)   issueIllegal_q <= decIllegal;
  end

  // One-cycle strobes registered out of the ISSUE state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluValid_q     <= 1'b0;
      illegalPulse_q <= 1'b0;
    end else begin
      aluValid_q     <= (state_q == ISSUE) && !issueIllegal_q;
      illegalPulse_q <= (state_q == ISSUE) &&  issueIllegal_q;
    end
  end

  assign alu_a_o     = aluA_q;
  assign alu_b_o     = aluB_q;
  assign alu_sel_o   = aluSel_q;
  assign alu_dst_o   = aluDst_q;
  assign alu_wb_o    = aluWb_q;
  assign alu_valid_o = aluValid_q;
  assign illegal_o   = illegalPulse_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and randomized checks of alu_issue_stage
// against a transaction-level reference model of registers and scoreboard.

module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        ins_valid_i;
  logic        ins_ready_o;
  logic [15:0] ins_word_i;
  logic [15:0] alu_a_o;
  logic [15:0] alu_b_o;
  logic [4:0]  alu_sel_o;
  logic [3:0]  alu_dst_o;
  logic        alu_wb_o;
  logic        alu_valid_o;
  logic        illegal_o;
`ifdef ALU_ISSUE_BYTE_EN
  logic        alu_byte_o;
`endif
  logic        wb_valid_i;
  logic        wb_en_i;
  logic [3:0]  wb_dst_i;
  logic [15:0] wb_data_i;

  int total = 0;
  int bad   = 0;

  // Reference state: architectural registers and outstanding destinations
  logic [15:0] mReg [16];
  logic [15:0] mPend;

  alu_issue_stage #(.NREG(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ins_valid_i (ins_valid_i),
    .ins_ready_o (ins_ready_o),
    .ins_word_i  (ins_word_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_sel_o   (alu_sel_o),
    .alu_dst_o   (alu_dst_o),
    .alu_wb_o    (alu_wb_o),
    .alu_valid_o (alu_valid_o),
    .illegal_o   (illegal_o),
`ifdef ALU_ISSUE_BYTE_EN
    .alu_byte_o  (alu_byte_o),
`endif
    .wb_valid_i  (wb_valid_i),
    .wb_en_i     (wb_en_i),
    .wb_dst_i    (wb_dst_i),
    .wb_data_i   (wb_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // What an instruction means, stated by mnemonic groups
  function automatic void refModel(input logic [15:0] w, output bit ill, output logic [4:0] sel,
                                   output logic [15:0] a, output logic [15:0] b, output logic [3:0] dst,
                                   output bit wr, output bit byteOp, output logic [15:0] useMask);
    logic [3:0]  op;
    logic [15:0] rs, rd;
    bit          isRrc;
    op     = w[15:12];
    isRrc  = (w[15:10] == 6'b000100) && (w[9:7] == 3'b000);
    byteOp = w[6];
    rs     = mReg[w[11:8]];
    rd     = mReg[w[3:0]];
`ifdef ALU_ISSUE_BYTE_EN
    if (byteOp) begin
      rs = rs & 16'h00ff;
      rd = rd & 16'h00ff;
    end
`endif
    ill = (w[5:4] != 2'b00);
    if (op >= 4'h4) begin
      if (w[7]) ill = 1'b1;
    end else if (!isRrc) begin
      ill = 1'b1;
    end
`ifndef ALU_ISSUE_BYTE_EN
    if (byteOp) ill = 1'b1;
`endif
    dst     = w[3:0];
    useMask = 16'h1 << w[3:0];
    if (op >= 4'h4) useMask = useMask | (16'h1 << w[11:8]);
    a  = 16'h0000;
    b  = 16'h0000;
    wr = !(op == 4'h9 || op == 4'hB);
    case (op)
      4'h4: sel = 5'b00000;  4'h5: sel = 5'b00001;  4'h6: sel = 5'b00010;  4'h7: sel = 5'b00100;
      4'h8: sel = 5'b00011;  4'h9: sel = 5'b00101;  4'hA: sel = 5'b00110;  4'hB: sel = 5'b00111;
      4'hC: sel = 5'b01000;  4'hD: sel = 5'b01001;  4'hE: sel = 5'b01010;  4'hF: sel = 5'b01011;
      default: sel = 5'b10000;
    endcase
    case (op)
      4'h4:                      b = rs;
      4'hB, 4'hC, 4'hD:          begin a = rs; b = rd; end
      4'h0, 4'h1, 4'h2, 4'h3:    b = rd;
      default:                   begin a = rd; b = rs; end
    endcase
  endfunction

  task automatic writeback(input logic [3:0] r, input logic [15:0] d, input bit en);
    @(negedge clk);
    wb_valid_i = 1'b1;
    wb_en_i    = en;
    wb_dst_i   = r;
    wb_data_i  = d;
    @(posedge clk);
    #1;
    wb_valid_i = 1'b0;
    wb_en_i    = 1'b0;
    if (en) mReg[r] = d;
    mPend[r] = 1'b0;
  endtask

  // Handshake one word; returns just after the accepting edge
  task automatic sendWord(input logic [15:0] w, output bit ok);
    int waitCycles;
    waitCycles = 0;
    @(negedge clk);
    while (!ins_ready_o && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("readyWait", ins_ready_o, 1);
    ok = ins_ready_o;
    if (ok) begin
      ins_valid_i = 1'b1;
      ins_word_i  = w;
      @(posedge clk);
      #1;
      ins_valid_i = 1'b0;
    end
  endtask

  // Issue one word, release any hazard it has, and check the issued result
  task automatic applyStimulus(input logic [15:0] w, input int extraStall);
    bit          ill, wr, byteOp, ok, seen;
    logic [4:0]  sel;
    logic [15:0] a, b, useMask, hazardMask;
    logic [3:0]  dst;
    int          n;
    refModel(w, ill, sel, a, b, dst, wr, byteOp, useMask);
    hazardMask = ill ? 16'h0 : (useMask & mPend);
    sendWord(w, ok);
    if (!ok) return;
    if (hazardMask != 16'h0) begin
      repeat (3 + extraStall) begin
        @(negedge clk);
        checkOutput("stallHold", {alu_valid_o, illegal_o, ins_ready_o}, 0);
      end
      for (int r = 0; r < 16; r++)
        if (hazardMask[r]) writeback(4'(r), 16'($urandom), 1'($urandom_range(0, 1)));
      refModel(w, ill, sel, a, b, dst, wr, byteOp, useMask);
    end
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 8) begin
      @(negedge clk);
      n++;
      seen = alu_valid_o | illegal_o;
    end
    checkOutput("latency", n, 3);
    if (seen) begin
      checkOutput("illegal", illegal_o, ill);
      checkOutput("valid", alu_valid_o, !ill);
      if (!ill) begin
        checkOutput("sel", alu_sel_o, sel);
        checkOutput("opA", alu_a_o, a);
        checkOutput("opB", alu_b_o, b);
        checkOutput("dst", alu_dst_o, dst);
        checkOutput("wbFlag", alu_wb_o, wr);
`ifdef ALU_ISSUE_BYTE_EN
        checkOutput("byteFlag", alu_byte_o, byteOp);
`endif
        if (wr) mPend[dst] = 1'b1;
      end
      @(negedge clk);
      checkOutput("pulseEnd", {alu_valid_o, illegal_o}, 0);
    end
  endtask

  initial begin
    bit          ok, ill, wr, byteOp;
    logic [4:0]  sel;
    logic [15:0] a, b, useMask, w;
    logic [3:0]  dst;
    int          choice;

    for (int i = 0; i < 16; i++) mReg[i] = 16'h0000;
    mPend       = 16'h0000;
    rst_n       = 1'b0;
    ins_valid_i = 1'b0;
    ins_word_i  = 16'h0000;
    wb_valid_i  = 1'b0;
    wb_en_i     = 1'b0;
    wb_dst_i    = 4'h0;
    wb_data_i   = 16'h0000;

    #12;
    checkOutput("rstReady", ins_ready_o, 0);
    checkOutput("rstOuts", {alu_valid_o, illegal_o, alu_wb_o, alu_sel_o, alu_dst_o}, 0);
    checkOutput("rstOps", {alu_a_o, alu_b_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("readyAfterRst", ins_ready_o, 1);

    // Preload through writebacks to non-pending registers
    writeback(4'd4, 16'h0003, 1'b1);
    writeback(4'd5, 16'h0010, 1'b1);
    writeback(4'd6, 16'h0100, 1'b1);
    writeback(4'd7, 16'h8001, 1'b1);

    applyStimulus(16'h5405, 0);
    applyStimulus(16'h4406, 0);
    applyStimulus(16'h9405, 1);
    applyStimulus(16'h5405, 0);

    // Issue and writeback of R5 on the same edge: the pending bit must stay set
    writeback(4'd4, 16'h0003, 1'b1);
    writeback(4'd5, 16'h0010, 1'b1);
    refModel(16'h5405, ill, sel, a, b, dst, wr, byteOp, useMask);
    sendWord(16'h5405, ok);
    writeback(4'd5, 16'h0077, 1'b1);
    mPend[5] = 1'b1;
    @(negedge clk);
    checkOutput("swEarly", alu_valid_o, 0);
    @(negedge clk);
    checkOutput("swValid", alu_valid_o, 1);
    checkOutput("swOpA", alu_a_o, a);
    applyStimulus(16'h8506, 0);

    // Writeback with wb_en low only clears the pending bit
    writeback(4'd6, 16'hdead, 1'b0);
    applyStimulus(16'h4607, 0);

    writeback(4'd7, 16'h8001, 1'b1);
    applyStimulus(16'h1007, 0);
    applyStimulus(16'h1087, 0);
    applyStimulus(16'h5425, 0);
    writeback(4'd4, 16'h1203, 1'b1);
    applyStimulus(16'h5445, 0);

    // Randomized mix of legal, RRC and arbitrary words with random writebacks
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0)
        writeback(4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
      choice = $urandom_range(0, 9);
      if (choice == 0)
        w = 16'($urandom);
      else if (choice == 1)
        w = {6'b000100, 3'b000, ($urandom_range(0, 7) == 0), 2'b00, 4'($urandom_range(0, 15))};
      else
        w = {4'($urandom_range(4, 15)), 4'($urandom_range(0, 15)), 1'b0,
             ($urandom_range(0, 7) == 0), 2'b00, 4'($urandom_range(0, 15))};
      applyStimulus(w, $urandom_range(0, 2));
    end

    // Reset while stalled in CHECK
    writeback(4'd4, 16'h0003, 1'b1);
    writeback(4'd5, 16'h0010, 1'b1);
    applyStimulus(16'h5405, 0);
    sendWord(16'h8506, ok);
    repeat (2) begin
      @(negedge clk);
      checkOutput("preRstStall", {alu_valid_o, illegal_o, ins_ready_o}, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOuts", {alu_valid_o, illegal_o, ins_ready_o, alu_wb_o, alu_sel_o, alu_dst_o}, 0);
    checkOutput("midRstOps", {alu_a_o, alu_b_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) mReg[i] = 16'h0000;
    mPend = 16'h0000;
    #1;
    checkOutput("readyAfterMidRst", ins_ready_o, 1);
    applyStimulus(16'h8506, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-and-issue stage sitting directly upstream of the 16-bit ALU. Accepts MSP430-style instruction words over a valid/ready handshake, decodes register-mode Format I and RRC, reads a 16×16 register file, and presents registered `A`/`B`/`sel` operands to the ALU. Accepts writeback results from downstream. Tracks outstanding destinations with a per-register pending scoreboard and stalls on RAW/WAW hazards.

## Interface

- `NREG`, default 16: register count; the 4-bit register fields are fixed.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `ins_valid`, in, 1: instruction word present.
- `ins_ready`, out, 1: stage can accept a word.
- `ins_word`, in, 16: instruction.
- `alu_a`, out, 16: ALU operand A.
- `alu_b`, out, 16: ALU operand B.
- `alu_sel`, out, 5: ALU operation select.
- `alu_dst`, out, 4: destination register.
- `alu_wb`, out, 1: result must be written back (0 for CMP and BIT).
- `alu_valid`, out, 1: issue strobe; outputs are valid this cycle.
- `illegal`, out, 1: one-cycle pulse for an undecodable word.
- `wb_valid`, in, 1: writeback returning.
- `wb_en`, in, 1: write `wb_data` to the register file.
- `wb_dst`, in, 4: writeback register.
- `wb_data`, in, 16: writeback value.

## Operation

- Format I layout: [15:12] op, [11:8] src, [7] Ad, [6] B/W, [5:4] As, [3:0] dst.
  - Op to sel: 4 MOV→00000; 5 ADD→00001; 6 ADDC→00010; 7 SUBC→00100; 8 SUB→00011; 9 CMP→00101; A DADD→00110; B BIT→00111; C BIC→01000; D BIS→01001; E XOR→01010; F AND→01011.
- Format II layout: [15:10]=000100, [9:7] opc, [6] B/W, [5:4] As, [3:0] reg. Only opc 000 (RRC→10000) is legal.
- Operands:
  - Arithmetic, CMP, XOR, AND: A=R[dst], B=R[src].
  - BIC, BIS, BIT: A=R[src], B=R[dst].
  - MOV: A=0, B=R[src].
  - RRC: A=0, B=R[reg], dst=reg.
- A word is illegal if any of these hold: Ad≠0, As≠00, op 0–3 other than Format II RRC, or (without the macro) B/W=1.
- Scoreboard: `pending[NREG-1:0]`.
  - Issue of a writing instruction sets `pending[dst]`.
  - `wb_valid` clears `pending[wb_dst]`.
  - `wb_valid & wb_en` also writes `wb_data` to R[wb_dst].
  - `wb_valid` with `wb_en=0` only clears the pending bit.
- FSM: IDLE → CHECK → ISSUE → IDLE.
  - IDLE: `ins_ready`=1. On a handshake, latch `ins_word` and go to CHECK.
  - CHECK: `ins_ready`=0.
    - Illegal word: go to ISSUE with the illegal flag set.
    - Otherwise, if any register read or written by the instruction is pending, stay in CHECK (stall).
    - Otherwise, register the operands, sel, dst and wb; set pending; go to ISSUE.
  - ISSUE: pulse `alu_valid` (or `illegal` instead), then return to IDLE. An illegal word sets no pending bit and drives `alu_valid`=0.
- Register file reads in CHECK return the pre-edge value; a same-cycle write is not bypassed.

## Timing

- Reset values: `ins_ready`=0 during reset and 1 in the first cycle after; `alu_a`, `alu_b`, `alu_sel`, `alu_dst`, `alu_wb`, `alu_valid`, `illegal` all 0; all registers 0; `pending`=0; state IDLE.
- Latency: word accepted at edge t → `alu_valid` high for the cycle after edge t+2 with no stall. Throughput is 1 instruction per 3 cycles.
- Operand outputs hold their values until the next issue.
- Stall release: a writeback at edge t clears `pending`; CHECK sees the bit clear in the cycle after edge t, and issue registers at edge t+1.
- Simultaneous set and clear of the same `pending` bit on one edge: set wins.
- Writeback to a non-pending register is allowed: the write occurs, and the pending bit stays 0.
- Reset asserted mid-operation: the latched word is discarded, `pending` is cleared, and `alu_valid`/`illegal` drop immediately.

## Configuration

- `ALU_ISSUE_BYTE_EN` defined:
  - B/W=1 is legal.
  - `alu_a` and `alu_b` are zero-extended from bits [7:0] of the register values.
  - An extra output `alu_byte` (1 bit, reset 0) carries B/W alongside `alu_valid`.
- Not defined:
  - B/W=1 raises `illegal`.
  - `alu_byte` does not exist.

## Test plan

- Preload R4=0x0003 and R5=0x0010 via writeback; issue 0x5405 (ADD R4,R5) → two cycles later `alu_valid`=1, `alu_sel`=00001, `alu_a`=0x0010, `alu_b`=0x0003, `alu_dst`=5, `alu_wb`=1.
- Issue 0x4406 (MOV R4,R6) → `alu_a`=0, `alu_b`=0x0003, `alu_sel`=00000. Issue 0x9405 (CMP) → `alu_sel`=00101, `alu_wb`=0, `pending[5]` unchanged.
- Issue 0x5405, then 0x8506 (SUB R5,R6) → holds in CHECK with `ins_ready`=0 and no `alu_valid`; drive a writeback with `wb_dst`=5, `wb_data`=0x0013 → SUB issues with `alu_a`=R6, `alu_b`=0x0013 in the cycle after the edge following the writeback.
- Preload R7=0x8001; issue 0x1007 (RRC R7) → `alu_sel`=10000, `alu_a`=0, `alu_b`=0x8001, `alu_dst`=7. Issue 0x1087 (Format II opc 001) → `illegal` pulses, `alu_valid`=0.
- Issue 0x5425 (As=10) → `illegal` pulses and no pending bit is set. Issue 0x5445 → `illegal` without `ALU_ISSUE_BYTE_EN`; with it, R4=0x1203 gives `alu_b`=0x0003 and `alu_byte`=1.
- Assert `rst_n`=0 while in CHECK stall → all outputs 0 and `pending`=0; after release, `ins_ready`=1 and the next word issues without a stall.
